regfile_dump_unit: RTL
======================

# regfile_dump_unit

Sequential reader for the integer register file: on a start pulse it walks register addresses FIRST_REG..NREGS-1 through one read port and streams each {address, value} pair out over a valid/ready handshake. It sits beside the datapath on a spare read port of `register_file`. It feeds the compliance-signature / debug output path, so the bench and UART bridge can dump architectural state at end of test.

## Interface
Parameters:
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers
- AW, 5, register address width; NREGS must equal 2**AW
- FIRST_REG, 0, first address dumped (1 skips x0)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  request a dump; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- rf_ra  out  AW  read address to the register file read port
- rf_rd  in  XLEN  combinational read data returned for rf_ra
- out_valid  out  1  out_addr/out_data hold a word
- out_ready  in  1  sink accepts the word when out_valid & out_ready
- out_addr  out  AW  register index of the current word
- out_data  out  XLEN  register value of the current word

## Operation
FSM states: IDLE, READ, SEND, DONE.
- IDLE: busy=0, out_valid=0. If start=1, then idx<=FIRST_REG and next state is READ.
- READ: rf_ra=idx. At the edge, out_data<=rf_rd and out_addr<=idx, then go to SEND.
- SEND: out_valid=1. out_addr and out_data are held stable until the handshake.
  - On handshake with idx==NREGS-1: go to DONE.
  - On handshake otherwise: idx<=idx+1 and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- rf_ra equals idx in every state. It is don't-care outside READ but must never be X; drive idx.
- Register values are snapshotted in the READ cycle. A write to the register file in that same cycle is seen with the register file's own read-during-write semantics. Later writes are not reflected in the word already held.
- start is ignored in READ, SEND and DONE; no queuing.
- start asserted in the DONE cycle is ignored. A new dump needs start in IDLE.
- idx is AW bits. It never wraps, because termination is checked at NREGS-1 before any increment.

## Timing
- Reset values: state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_addr=0, out_data=0, rf_ra=0.
- Reset mid-dump: at the next edge everything returns to reset values. The partial dump is abandoned, and no done pulse is produced.
- start sampled high at edge k: busy=1 after k. First out_valid=1 after edge k+1.
- Each word costs 2 cycles (READ + SEND) with out_ready held high. A full dump with FIRST_REG=0 takes 64 cycles from the first READ, plus 1 DONE cycle.
- out_ready low stalls in SEND indefinitely. out_valid must not drop, and out_addr/out_data must not change while stalled.
- done is asserted the cycle after the final handshake, and busy falls with the return to IDLE on the following edge.
- out_valid never depends combinationally on out_ready.

## Structure
- Shared package `riscv_pkg`: XLEN, REG_AW and NREGS constants, plus typedef enum `dump_state_t` {IDLE, READ, SEND, DONE}.
- Single module with no sub-module.
- In the bench, the register file read port is an instance of `register_file`.

## Test plan
- Preload x5=32'h5, x7=32'h7 and all others zero. Pulse start with out_ready=1 and FIRST_REG=0. Expect 32 words, in order, with addr 0..31. Words at addr 5 and 7 carry data 5 and 7; all others are 0. Expect done one cycle after the addr-31 handshake.
- Hold out_ready=0 for 10 cycles at the first SEND. Expect out_valid to stay 1 with addr 0 and data stable. Release ready and expect the stream to continue with addr 1.
- Set FIRST_REG=1. Expect exactly 31 words, addr 1..31, and no word for x0.
- Assert reset at the SEND of addr 12. Next cycle expect busy=0, out_valid=0 and all outputs 0. No done pulse.
- Re-pulse start during SEND of addr 3. Expect the dump to be unaffected and exactly one done. After returning to IDLE, a new start produces a full second dump.
- Write x9=32'hDEADBEEF via the write port while the dump sits at addr 20. Expect the addr 9 word to keep its old value; a second dump shows 32'hDEADBEEF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared integer-core constants and the register dump sequencer state encoding.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: one synchronous write port and one combinational read port.
// x0 always reads zero. A read in the same cycle as a write returns the old value.
module register_file #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] regs_reg [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs_reg[wa] <= wd;
    end
  end

  assign rd = (ra == '0) ? '0 : regs_reg[ra];

endmodule

// File: rtl/regfile_dump_unit.sv
// Walks register addresses FIRST_REG..NREGS-1 on a start pulse and streams each
// {address, value} pair out over a valid/ready handshake.
module regfile_dump_unit #(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int NREGS     = riscv_pkg::NREGS,
  parameter int AW        = riscv_pkg::REG_AW,
  parameter int FIRST_REG = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   rf_ra,
  input  logic [XLEN-1:0] rf_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_addr,
  output logic [XLEN-1:0] out_data
);

  import riscv_pkg::*;

  dump_state_t     state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [XLEN-1:0] data_reg, data_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    busy       = 1'b1;
    done       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_next   = AW'(FIRST_REG);
          state_next = READ;
        end
      end
      READ: begin
        // Snapshot taken here; later register writes do not alter the held word.
        addr_next  = idx_reg;
        data_next  = rf_rd;
        state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Termination is tested before the increment, so idx never wraps.
          if (idx_reg == AW'(NREGS - 1)) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + AW'(1);
            state_next = READ;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rf_ra    = idx_reg;
  assign out_addr = addr_reg;
  assign out_data = data_reg;

endmodule
